// File: rtl/window_acc_pkg.sv
// Shared constants and helpers for the windowed sample accumulator.
package window_acc_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width of the per-window sample counter.
  function automatic int cnt_width(input int window);
    return $clog2(window);
  endfunction

endpackage

// File: rtl/window_accumulator_sat_adder.sv
// Zero-extend a sample, add it to the running sum, and report the carry.
// In saturate mode a carry clamps the result to all-ones; otherwise it wraps.
module sat_adder
  import window_acc_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int ACC_W = 5
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_sat,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + (ACC_W+1)'(i_data);
  assign o_carry = w_full[ACC_W];
  assign o_sum   = (o_carry && (i_sat == MODE_SAT)) ? '1 : w_full[ACC_W-1:0];

endmodule

// File: rtl/window_accumulator.sv
// Running accumulator over WINDOW accepted samples; emits the window total
// with a one-cycle strobe and restarts. Window position lives entirely in
// count: FILL while count < WINDOW-1, LAST at WINDOW-1.
module window_accumulator
  import window_acc_pkg::*;
#(
  parameter int IN_W     = 3,
  parameter int ACC_W    = 5,
  parameter int WINDOW   = 8,
  parameter int ZERO_CLR = 1,
  parameter int CNT_W    = cnt_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             clear,
  input  logic             sat_mode,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf_win;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_overflow;

  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic             w_zero;
  logic             w_last;

  sat_adder #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .i_acc   (r_acc),
    .i_data  (in_data),
    .i_sat   (sat_mode),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_zero = (ZERO_CLR != 0) && (in_data == '0);
  assign w_last = (r_count == LAST_CNT);

  // Priority: clear, zero-restart, accumulate, complete; idle holds state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf_win   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (clear) begin
        r_acc     <= '0;
        r_count   <= '0;
        r_ovf_win <= 1'b0;
      end else if (in_valid) begin
        if (w_zero) begin
          r_acc     <= '0;
          r_count   <= '0;
          r_ovf_win <= 1'b0;
        end else if (!w_last) begin
          r_acc     <= w_sum;
          r_count   <= r_count + CNT_W'(1);
          r_ovf_win <= r_ovf_win | w_carry;
        end else begin
          r_out_sum   <= w_sum;
          r_overflow  <= r_ovf_win | w_carry;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_count     <= '0;
          r_ovf_win   <= 1'b0;
        end
      end
    end
  end

  assign acc       = r_acc;
  assign count     = r_count;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_window_accumulator.sv
// Table-driven bench for window_accumulator with a completion scoreboard.
// dut0 counts zero samples as ordinary samples, dut1 restarts on them.
module tb_window_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_data;
  logic       clear;
  logic       sat_mode;

  logic [4:0] o0_acc, o1_acc, o0_sum, o1_sum;
  logic [2:0] o0_cnt, o1_cnt;
  logic       o0_ov, o1_ov, o0_ovf, o1_ovf;

  always #5 clk = ~clk;

  window_accumulator #(.IN_W(3), .ACC_W(5), .WINDOW(8), .ZERO_CLR(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .sat_mode(sat_mode), .acc(o0_acc), .count(o0_cnt),
    .out_valid(o0_ov), .out_sum(o0_sum), .overflow(o0_ovf)
  );

  window_accumulator #(.IN_W(3), .ACC_W(5), .WINDOW(8), .ZERO_CLR(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .sat_mode(sat_mode), .acc(o1_acc), .count(o1_cnt),
    .out_valid(o1_ov), .out_sum(o1_sum), .overflow(o1_ovf)
  );

  typedef struct {
    bit       sel;
    bit       v;
    int       d;
    bit       clr;
    bit       sat;
    int       e_acc;
    int       e_cnt;
    bit       e_ov;
    int       e_sum;
    bit       e_ovf;
  } vec_t;

  typedef struct {
    int sum;
    bit ovf;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input bit sel, input bit v, input int d, input bit clr, input bit sat,
                     input int ea, input int ec, input bit eov, input int es, input bit eovf);
    vec_t t;
    t.sel = sel; t.v = v; t.d = d; t.clr = clr; t.sat = sat;
    t.e_acc = ea; t.e_cnt = ec; t.e_ov = eov; t.e_sum = es; t.e_ovf = eovf;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t t, input int idx);
    sb_t e;
    @(negedge clk);
    in_valid = t.v;
    in_data  = 3'(t.d);
    clear    = t.clr;
    sat_mode = t.sat;
    if (t.e_ov && !t.sel) begin
      e.sum = t.e_sum;
      e.ovf = t.e_ovf;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!t.sel) begin
      chk($sformatf("v%0d acc", idx), 32'(o0_acc), 32'(t.e_acc));
      chk($sformatf("v%0d count", idx), 32'(o0_cnt), 32'(t.e_cnt));
      chk($sformatf("v%0d out_valid", idx), 32'(o0_ov), 32'(t.e_ov));
      chk($sformatf("v%0d out_sum", idx), 32'(o0_sum), 32'(t.e_sum));
      chk($sformatf("v%0d overflow", idx), 32'(o0_ovf), 32'(t.e_ovf));
    end else begin
      chk($sformatf("z%0d acc", idx), 32'(o1_acc), 32'(t.e_acc));
      chk($sformatf("z%0d count", idx), 32'(o1_cnt), 32'(t.e_cnt));
      chk($sformatf("z%0d out_valid", idx), 32'(o1_ov), 32'(t.e_ov));
      chk($sformatf("z%0d out_sum", idx), 32'(o1_sum), 32'(t.e_sum));
      chk($sformatf("z%0d overflow", idx), 32'(o1_ovf), 32'(t.e_ovf));
    end
  endtask

  // Scoreboard consumer: every dut0 strobe must match the oldest expected window.
  always @(posedge clk) begin
    #1;
    if (o0_ov === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb unexpected out_valid", 32'(o0_ov), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb out_sum", 32'(o0_sum), 32'(e.sum));
        chk("sb overflow", 32'(o0_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    int d1[8];
    int a1[8];
    int idx;
    d1 = '{1, 2, 3, 4, 5, 6, 7, 1};
    a1 = '{1, 3, 6, 10, 15, 21, 28, 0};

    // No overflow, wrap: total 29.
    for (int i = 0; i < 8; i++)
      add(0, 1, d1[i], 0, 0, a1[i], (i + 1) % 8, i == 7, (i == 7) ? 29 : 0, 0);
    // Wrap: eight 7s -> 56 mod 32 = 24, overflow.
    add(0,1,7,0,0, 7,1,0,29,0); add(0,1,7,0,0,14,2,0,29,0);
    add(0,1,7,0,0,21,3,0,29,0); add(0,1,7,0,0,28,4,0,29,0);
    add(0,1,7,0,0, 3,5,0,29,0); add(0,1,7,0,0,10,6,0,29,0);
    add(0,1,7,0,0,17,7,0,29,0); add(0,1,7,0,0, 0,0,1,24,1);
    // Back-to-back window of 1s: 8, no overflow.
    for (int i = 1; i <= 7; i++) add(0, 1, 1, 0, 0, i, i, 0, 24, 1);
    add(0,1,1,0,0, 0,0,1,8,0);
    // Saturate: clamps at 31 from the 5th sample.
    add(0,1,7,0,1, 7,1,0,8,0); add(0,1,7,0,1,14,2,0,8,0);
    add(0,1,7,0,1,21,3,0,8,0); add(0,1,7,0,1,28,4,0,8,0);
    add(0,1,7,0,1,31,5,0,8,0); add(0,1,7,0,1,31,6,0,8,0);
    add(0,1,7,0,1,31,7,0,8,0); add(0,1,7,0,1, 0,0,1,31,1);
    // Clear wins over a valid sample at count=5.
    for (int i = 1; i <= 5; i++) add(0, 1, 1, 0, 0, i, i, 0, 31, 1);
    add(0,1,4,1,0, 0,0,0,31,1);
    // Gapped stream gives the same total as the contiguous one.
    for (int i = 0; i < 8; i++) begin
      add(0, 1, d1[i], 0, 0, a1[i], (i + 1) % 8, i == 7, (i == 7) ? 29 : 31, i != 7);
      add(0, 0, 7, 0, 0, a1[i], (i + 1) % 8, 0, (i == 7) ? 29 : 31, i != 7);
    end
    // Zero-clear on dut1: 3,5,0,2.
    add(1,1,3,0,0,3,1,0,29,0); add(1,1,5,0,0,8,2,0,29,0);
    add(1,1,0,0,0,0,0,0,29,0); add(1,1,2,0,0,2,1,0,29,0);
    // Prepare for the reset test: restart, then five 3s.
    add(0,0,0,1,0,0,0,0,29,0);
    for (int i = 1; i <= 5; i++) add(0, 1, 3, 0, 0, 3 * i, i, 0, 29, 0);

    rst = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; sat_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset acc", 32'(o0_acc), 32'd0);
    chk("reset count", 32'(o0_cnt), 32'd0);
    chk("reset out_valid", 32'(o0_ov), 32'd0);
    chk("reset out_sum", 32'(o0_sum), 32'd0);
    chk("reset overflow", 32'(o0_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    idx = 0;
    foreach (vecs[i]) begin
      apply(vecs[i], idx);
      idx++;
    end

    // Asynchronous reset mid-window, checked before the next edge.
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async acc", 32'(o0_acc), 32'd0);
    chk("async count", 32'(o0_cnt), 32'd0);
    chk("async out_valid", 32'(o0_ov), 32'd0);
    chk("async out_sum", 32'(o0_sum), 32'd0);
    chk("async overflow", 32'(o0_ovf), 32'd0);
    chk("async dut1 acc", 32'(o1_acc), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full window after release counts only post-reset samples: 8*2 = 16.
    vecs.delete();
    for (int i = 1; i <= 7; i++) add(0, 1, 2, 0, 0, 2 * i, i, 0, 0, 0);
    add(0,1,2,0,0,0,0,1,16,0);
    add(0,0,0,0,0,0,0,0,16,0);
    foreach (vecs[i]) begin
      apply(vecs[i], idx);
      idx++;
    end

    chk("sb drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
